// File: rtl/sdpram_bist_ctrl.sv
// Built-in self-test engine for simple dual-port RAMs: pattern write, optional
// byte-lane rewrite, latency-matched readback compare with error capture.
module sdpram_bist_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int BE_WIDTH   = 1,
  parameter int OUTPUT_REG = 0,
  parameter int BE_TEST    = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            pattern,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int LW    = DATA_WIDTH / BE_WIDTH;
  localparam int RL    = 1 + OUTPUT_REG;
  localparam bit BE_PH = (BE_TEST != 0) && (BE_WIDTH > 1);
  localparam int IW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, WRITE, WRITE_BE, READ, DRAIN, DONE} state_e;

  function automatic logic [DATA_WIDTH-1:0] pat_f(input logic [1:0] p,
                                                  input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] ext;
    logic [DATA_WIDTH-1:0]            r;
    ext = {{DATA_WIDTH{1'b0}}, a};
    r   = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      case (p)
        2'd0:    r[b] = ~ext[b];
        2'd1:    r[b] = ext[b];
        2'd2:    r[b] = ((b % 2) == 0) ^ a[0];
        default: r[b] = (b == (int'(a) % DATA_WIDTH));
      endcase
    end
    return r;
  endfunction

  state_e                           state_q;
  logic [IW-1:0]                    idx_q;
  logic [1:0]                       pat_q;
  logic [1:0]                       drain_q;
  logic                             wr_en_q, busy_q, done_q, pass_q;
  logic [ADDR_WIDTH-1:0]            wr_addr_q, ferr_q;
  logic [DATA_WIDTH-1:0]            wr_data_q;
  logic [BE_WIDTH-1:0]              wr_be_q;
  logic [ERR_CNT_W-1:0]             err_q;
  logic [RL:0]                      vld_pipe;
  logic [RL:0][ADDR_WIDTH-1:0]      idx_pipe;

  logic [DATA_WIDTH-1:0] lane_inv, pat_cur, exp_d;
  logic [BE_WIDTH-1:0]   be_even;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [IW-1:0]         idx_nxt;
  logic                  last, mismatch;

  // Even lanes are the ones rewritten with inverted data in the byte-lane phase.
  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_lane_inv
    assign lane_inv[b] = ((b / LW) % 2) == 0;
  end
  for (genvar k = 0; k < BE_WIDTH; k++) begin : g_be_even
    assign be_even[k] = (k % 2) == 0;
  end

  // At the end of a phase the index wraps to address 0, so the next phase's
  // first access is issued on the same edge without a bubble.
  assign cur_addr = idx_q[ADDR_WIDTH-1:0];
  assign last     = idx_q[ADDR_WIDTH];
  assign idx_nxt  = {1'b0, cur_addr} + 1'b1;
  assign pat_cur  = pat_f(pat_q, cur_addr);
  assign exp_d    = pat_f(pat_q, idx_pipe[RL]) ^ (BE_PH ? lane_inv : '0);
  assign mismatch = vld_pipe[RL] && !(busy_q && abort) && (ram_rd_data != exp_d);

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pat_q     <= '0;
      drain_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      vld_pipe  <= '0;
      idx_pipe  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ferr_q    <= '0;
    end else begin
      wr_en_q     <= 1'b0;
      wr_be_q     <= '0;
      vld_pipe[0] <= 1'b0;
      for (int s = 1; s <= RL; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
      if (mismatch) begin
        if (err_q != '1) err_q <= err_q + 1'b1;
        if (err_q == '0) ferr_q <= idx_pipe[RL];
      end
      if (busy_q && abort) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        vld_pipe <= '0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start && !abort) begin
              state_q   <= WRITE;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              pass_q    <= 1'b0;
              err_q     <= '0;
              ferr_q    <= '0;
              pat_q     <= pattern;
              wr_en_q   <= 1'b1;
              wr_addr_q <= '0;
              wr_data_q <= pat_f(pattern, '0);
              wr_be_q   <= '1;
              idx_q     <= IW'(1);
            end
          end
          WRITE: begin
            idx_q <= idx_nxt;
            if (!last) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cur_addr;
              wr_data_q <= pat_cur;
              wr_be_q   <= '1;
            end else if (BE_PH) begin
              state_q   <= WRITE_BE;
              wr_en_q   <= 1'b1;
              wr_addr_q <= cur_addr;
              wr_data_q <= ~pat_cur;
              wr_be_q   <= be_even;
            end else begin
              state_q     <= READ;
              vld_pipe[0] <= 1'b1;
              idx_pipe[0] <= cur_addr;
            end
          end
          WRITE_BE: begin
            idx_q <= idx_nxt;
            if (!last) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cur_addr;
              wr_data_q <= ~pat_cur;
              wr_be_q   <= be_even;
            end else begin
              state_q     <= READ;
              vld_pipe[0] <= 1'b1;
              idx_pipe[0] <= cur_addr;
            end
          end
          READ: begin
            if (!last) begin
              vld_pipe[0] <= 1'b1;
              idx_pipe[0] <= cur_addr;
              idx_q       <= idx_nxt;
            end else begin
              state_q <= DRAIN;
              drain_q <= '0;
            end
          end
          DRAIN: begin
            // Holds until the last compare has landed in err_q.
            if (drain_q == 2'(RL)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_q == '0);
            end else begin
              drain_q <= drain_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ram_wr_en      = wr_en_q;
  assign ram_wr_addr    = wr_addr_q;
  assign ram_wr_data    = wr_data_q;
  assign ram_wr_byte_en = wr_be_q;
  assign ram_rd_en      = vld_pipe[0];
  assign ram_rd_addr    = idx_pipe[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;

endmodule
